// File: rtl/ibex_instr_tcm_bridge.sv
// Bridges the prefetch buffer's req/gnt/rvalid instruction port onto a shared fixed-latency TCM.
// Fetches outside the TCM window get a local error response that keeps its place in the response order.
module ibex_instr_tcm_bridge #(
    parameter logic [31:0] TcmBase        = 32'h0010_0000,
    parameter logic [31:0] TcmSize        = 32'h0001_0000,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          ResetAll       = 1'b0,
    localparam int unsigned WinW          = $clog2(TcmSize),
    localparam int unsigned SramAw        = WinW - 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,

    output logic              sram_req_o,
    input  logic              sram_gnt_i,
    output logic [SramAw-1:0] sram_addr_o,
    input  logic [31:0]       sram_rdata_i,

    output logic              busy_o
);

    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [ReadLatency-1:0] vld_q, vld_d;
    logic [ReadLatency-1:0] err_q, err_d;
    logic                   in_win;
    logic                   can_issue;
    logic                   grant;
    logic                   rvalid;
    logic                   rerr;

    assign in_win    = instr_addr_i[31:WinW] == TcmBase[31:WinW];
    // Registered count only: a slot freed by this cycle's rvalid becomes usable next cycle.
    assign can_issue = cnt_q < CntMax;

    assign sram_req_o  = instr_req_i & in_win & can_issue;
    assign sram_addr_o = instr_addr_i[WinW-1:2];
    assign grant       = in_win ? (sram_req_o & sram_gnt_i) : (instr_req_i & can_issue);
    assign instr_gnt_o = grant;

    assign rvalid         = vld_q[ReadLatency-1];
    assign rerr           = err_q[ReadLatency-1];
    assign instr_rvalid_o = rvalid;
    assign instr_err_o    = rvalid & rerr;
    assign instr_rdata_o  = (rvalid & ~rerr) ? sram_rdata_i : 32'h0;

    assign busy_o = (cnt_q != '0) | instr_req_i;

    // Error responses travel the same pipe as SRAM reads so ordering needs no extra tracking.
    if (ReadLatency > 1) begin : g_shift
        assign vld_d = {vld_q[ReadLatency-2:0], grant};
        assign err_d = {err_q[ReadLatency-2:0], ~in_win};
    end else begin : g_single
        assign vld_d = grant;
        assign err_d = ~in_win;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (grant && !rvalid) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!grant && rvalid) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    // The err bits are only ever observed qualified by a valid bit, so their reset is optional.
    if (ResetAll) begin : g_err_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                err_q <= '0;
            end else begin
                err_q <= err_d;
            end
        end
    end else begin : g_err_norst
        always_ff @(posedge clk_i) begin
            err_q <= err_d;
        end
    end

    a_rvalid_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid |-> (cnt_q != '0));
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntMax);
    a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_req_i |-> (instr_addr_i[1:0] == 2'b00));
    a_lat_range: assert property (@(posedge clk_i)
        (ReadLatency >= 1) && (ReadLatency <= 3));

endmodule
